// File: rtl/dmem_responder_if.sv
// Processor data-port bus between a requester and dmem_responder.
// The master drives request fields; the slave returns data and status.
interface dmem_responder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output req, we, addr, din,
    input  dout, ready, busy, err
  );

  modport slave (
    input  req, we, addr, din,
    output dout, ready, busy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data memory responder: IDLE -> WAIT -> RESP, one access per request.
// Optional even-parity protection of each word is enabled with macro DMEM_PARITY_EN.
module dmem_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
`ifdef DMEM_PARITY_EN
  localparam int         MEM_W   = DATA_W + 1;
`else
  localparam int         MEM_W   = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic [DATA_W-1:0]   r_dout;
  logic                r_ready;
  logic                r_busy;
  logic [MEM_W-1:0]    r_mem [DEPTH];

  logic                w_accept;
  logic                w_enter_resp;
  logic                w_acc_we;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_din;
  logic [MEM_W-1:0]    w_rd_word;
  logic [MEM_W-1:0]    w_wr_word;

  function automatic logic f_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign w_accept     = (r_state == S_IDLE) && bus.req;
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // With zero wait states the access happens on the accepting edge itself,
  // before the request fields have been latched, so take them from the bus.
  assign w_acc_we   = (r_state == S_IDLE) ? bus.we   : r_we;
  assign w_acc_addr = (r_state == S_IDLE) ? bus.addr : r_addr;
  assign w_acc_din  = (r_state == S_IDLE) ? bus.din  : r_din;
  assign w_rd_word  = r_mem[w_acc_addr];

`ifdef DMEM_PARITY_EN
  assign w_wr_word = {f_parity(w_acc_din), w_acc_din};
`else
  assign w_wr_word = w_acc_din;
`endif

  // Array contents survive reset; an aborted transaction never reaches here.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_acc_we) begin
      r_mem[w_acc_addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_dout  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= w_enter_resp;
      if (w_enter_resp) begin
        r_dout <= w_acc_we ? w_acc_din : w_rd_word[DATA_W-1:0];
      end
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_din   <= bus.din;
            r_cnt   <= LP_WAIT;
            r_busy  <= 1'b1;
            r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_PARITY_EN
  logic r_err;

  // err is only meaningful alongside ready, so it drops again after RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_enter_resp && !w_acc_we &&
               (f_parity(w_rd_word[DATA_W-1:0]) != w_rd_word[DATA_W]);
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.dout  = r_dout;
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
// Expected values are hand-computed constants per transaction.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef DMEM_PARITY_EN
  localparam logic PAR_ERR_EXP = 1'b1;
`else
  localparam logic PAR_ERR_EXP = 1'b0;
`endif

  dmem_responder_if #(.ADDR_W(5), .DATA_W(16)) if_a ();
  dmem_responder_if #(.ADDR_W(5), .DATA_W(16)) if_b ();

  dmem_responder #(.ADDR_W(5), .DATA_W(16), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  dmem_responder #(.ADDR_W(5), .DATA_W(16), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the two-wait-state instance; optionally disturbs the bus mid-WAIT.
  task automatic xa(input logic w, input logic [4:0] a, input logic [15:0] d,
                    input bit disturb, output logic [15:0] q, output logic e,
                    output int lat, output int nbusy);
    if_a.req = 1'b1; if_a.we = w; if_a.addr = a; if_a.din = d;
    step();
    lat = 1; nbusy = 0;
    if (if_a.busy) nbusy++;
    if (disturb) begin
      if_a.addr = 5'd8; if_a.din = 16'hFFFF;
    end
    while (!if_a.ready && lat < 20) begin
      step();
      lat++;
      if (if_a.busy) nbusy++;
    end
    q = if_a.dout; e = if_a.err;
    if_a.req = 1'b0;
    step();
    chk("a_post_ready", if_a.ready, 0);
    chk("a_post_busy", if_a.busy, 0);
  endtask

  task automatic rd_a(input logic [4:0] a, input logic [15:0] exp_d, input logic exp_e, input string tag);
    logic [15:0] q; logic e; int lat, nb;
    xa(1'b0, a, 16'h0000, 1'b0, q, e, lat, nb);
    chk({tag, "_dout"}, q, exp_d);
    chk({tag, "_err"}, e, exp_e);
    chk({tag, "_lat"}, lat, 3);
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [15:0] d, input bit disturb, input string tag);
    logic [15:0] q; logic e; int lat, nb;
    xa(1'b1, a, d, disturb, q, e, lat, nb);
    chk({tag, "_dout"}, q, d);
    chk({tag, "_err"}, e, 0);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_busy_cycles"}, nb, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0]  a5;
    logic [15:0] exp_d;

    reset = 1'b1;
    if_a.req = 1'b0; if_a.we = 1'b0; if_a.addr = '0; if_a.din = '0;
    if_b.req = 1'b0; if_b.we = 1'b0; if_b.addr = '0; if_b.din = '0;
    step(); step();
    reset = 1'b0;

    // Reset state held through idle cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_a_ready", if_a.ready, 0);
      chk("rst_a_busy", if_a.busy, 0);
      chk("rst_a_dout", if_a.dout, 0);
      chk("rst_a_err", if_a.err, 0);
      chk("rst_b_ready", if_b.ready, 0);
      chk("rst_b_busy", if_b.busy, 0);
      chk("rst_b_dout", if_b.dout, 0);
      chk("rst_b_err", if_b.err, 0);
    end

    // Basic write then read-back with two wait states
    wr_a(5'd3, 16'hBEEF, 1'b0, "wr3");
    rd_a(5'd3, 16'hBEEF, 1'b0, "rd3");

    // Bus changes during WAIT must be ignored
    wr_a(5'd8, 16'h0808, 1'b0, "wr8");
    wr_a(5'd7, 16'h1234, 1'b1, "wr7_disturbed");
    rd_a(5'd7, 16'h1234, 1'b0, "rd7");
    rd_a(5'd8, 16'h0808, 1'b0, "rd8");

    // Reset during WAIT aborts a pending write
    wr_a(5'd5, 16'h5555, 1'b0, "wr5");
    if_a.req = 1'b1; if_a.we = 1'b1; if_a.addr = 5'd5; if_a.din = 16'hAAAA;
    step();
    chk("abort_busy_in_wait", if_a.busy, 1);
    if_a.req = 1'b0;
    reset = 1'b1;
    step();
    chk("abort_ready", if_a.ready, 0);
    chk("abort_busy", if_a.busy, 0);
    chk("abort_dout_cleared", if_a.dout, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_ready", if_a.ready, 0);
    end
    rd_a(5'd5, 16'h5555, 1'b0, "rd5_after_abort");

    // Reset wins over a simultaneous request
    if_a.req = 1'b1; if_a.we = 1'b1; if_a.addr = 5'd6; if_a.din = 16'h6666;
    reset = 1'b1;
    step();
    chk("rst_prio_busy", if_a.busy, 0);
    chk("rst_prio_ready", if_a.ready, 0);
    if_a.req = 1'b0;
    reset = 1'b0;
    step();
    chk("rst_prio_idle_busy", if_a.busy, 0);

    // Corrupt a stored data bit behind the design's back
    wr_a(5'd2, 16'h0001, 1'b0, "wr2");
    u_a.r_mem[2][0] = ~u_a.r_mem[2][0];
    rd_a(5'd2, 16'h0000, PAR_ERR_EXP, "rd2_flipped");
    rd_a(5'd3, 16'hBEEF, 1'b0, "rd3_clean");

    // Zero-wait instance: req held high, 32 writes then 32 reads
    if_b.req = 1'b1;
    for (int k = 0; k < 64; k++) begin
      a5 = k[4:0];
      exp_d = {3'b000, a5, 3'b000, a5};
      if_b.we = (k < 32);
      if_b.addr = a5;
      if_b.din = exp_d;
      step();
      chk("b_ready_resp", if_b.ready, 1);
      chk("b_busy_resp", if_b.busy, 1);
      chk("b_dout", if_b.dout, exp_d);
      if (k == 63) if_b.req = 1'b0;
      step();
      chk("b_ready_idle", if_b.ready, 0);
      chk("b_busy_idle", if_b.busy, 0);
    end
    step();
    chk("b_final_ready", if_b.ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 5, word-address width; the array holds 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states inserted before each access completes; legal range 0..15.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  1  access request from the processor data port.
REQ-008 we  input  1  1 = write, 0 = read; qualified by req.
REQ-009 addr  input  ADDR_W  word address; qualified by req.
REQ-010 din  input  DATA_W  write data; qualified by req.
REQ-011 dout  output  DATA_W  read data, registered; valid while ready=1.
REQ-012 ready  output  1  one-cycle completion strobe.
REQ-013 busy  output  1  high while a transaction is in flight (WAIT or RESP).
REQ-014 err  output  1  parity error on a read; valid while ready=1.

Function
REQ-015 The FSM SHALL have three states, IDLE, WAIT and RESP, all registered.
REQ-016 In IDLE, a rising edge with req=1 SHALL latch we, addr and din, and load the wait counter with WAIT_CYCLES.
- On that edge the FSM goes to WAIT if WAIT_CYCLES>0, else directly to RESP.
REQ-017 WAIT SHALL decrement the counter each edge and move to RESP on the edge at which the counter equals 1.
REQ-018 The array access SHALL occur on the edge entering RESP.
- Write: the array word at the latched addr is updated.
- Read: dout is loaded from the array.
- Write: dout is loaded with the written data.
REQ-019 ready SHALL be 1 exactly in RESP.
- Latency is WAIT_CYCLES+1 edges from the accepting edge.
REQ-020 RESP SHALL return to IDLE on the next edge unconditionally.
REQ-021 req, we, addr and din SHALL be ignored in WAIT and RESP; latched values alone determine the access.
REQ-022 A req still high in IDLE after RESP SHALL be accepted as a new transaction.
- Back-to-back spacing is therefore WAIT_CYCLES+2 cycles.
REQ-023 A read of an address written by the immediately preceding transaction SHALL return the new data.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 dout SHALL hold its last value outside RESP.
REQ-026 Address wrap: all 2^ADDR_W addresses are valid; no out-of-range condition exists.

Reset
REQ-027 reset SHALL force state=IDLE, counter=0, dout=0, ready=0, busy=0 and err=0 on the next edge.
REQ-028 Reset during WAIT SHALL abort the transaction; a pending write SHALL NOT modify the array.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 reset SHALL take priority over req on the same edge.

Configuration
REQ-031 With macro DMEM_PARITY_EN defined:
- Each word stores DATA_W+1 bits, including an even-parity bit computed on write.
- On a read in RESP, err=1 if the recomputed parity mismatches the stored parity, else 0.
- err=0 for writes.
REQ-032 Without DMEM_PARITY_EN:
- The array is DATA_W bits wide.
- err SHALL be constant 0.

Verification
REQ-033 Reset, then idle 5 cycles -> ready=0, busy=0, dout=0, err=0 throughout.
REQ-034 WAIT_CYCLES=2: write 0xBEEF to addr 3, then read addr 3.
- Write: ready high exactly 3 edges after accept, busy high for 3 cycles.
- Read: dout=0xBEEF with ready.
REQ-035 WAIT_CYCLES=0: req held high for writes to addrs 0..31 (data = addr*0x0101), then read back all 32 addresses.
- ready pulses every 2nd cycle.
- Every read value matches; addr 31 wraps correctly with no aliasing.
REQ-036 Write 0x1234 to addr 7, change addr/din to 8/0xFFFF mid-WAIT.
- Only addr 7 is written.
- A later read of addr 8 returns its prior value.
REQ-037 Write 0xAAAA to addr 5, assert reset during WAIT, then read addr 5.
- Old value returned; ready never asserted for the aborted write.
REQ-038 DMEM_PARITY_EN defined: write 0x0001 to addr 2, backdoor-flip stored data bit 0, read addr 2.
- err=1 with ready.
- Without the macro, the same sequence gives err=0.
